// File: rtl/color_bbox_accum_if.sv
// Pixel-mask input stream and per-frame result handshake between the mask
// stage, the bounding-box accumulator and the paddle tracker.
interface color_bbox_accum_if #(
  parameter int X_W   = 10,
  parameter int Y_W   = 10,
  parameter int CNT_W = 19
);
  logic                       in_valid;
  logic                       sof;
  logic [1:0]                 colorEncoding;
  logic                       res_ready;
  logic                       res_valid;
  logic [1:0]                 found;
  logic [2*X_W+2*Y_W-1:0]     c1_box;
  logic [2*X_W+2*Y_W-1:0]     c2_box;
  logic [CNT_W-1:0]           c1_count;
  logic [CNT_W-1:0]           c2_count;
  logic                       overrun;

  modport slave (
    input  in_valid, sof, colorEncoding, res_ready,
    output res_valid, found, c1_box, c2_box, c1_count, c2_count, overrun
  );

  modport master (
    output in_valid, sof, colorEncoding, res_ready,
    input  res_valid, found, c1_box, c2_box, c1_count, c2_count, overrun
  );
endinterface

// File: rtl/color_bbox_accum.sv
// Per-frame pixel count and bounding box for two mask colours, published once
// per frame over a valid/ready handshake. Index 1 = colour 1, index 0 = colour 2.
module color_bbox_accum #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int CNT_W   = 19,
  parameter int MIN_PIX = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  color_bbox_accum_if.slave   bus
);
  localparam int BOX_W = 2*X_W + 2*Y_W;
  localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0] cnt_q [2], cnt_d [2];
  logic             hit_q [2], hit_d [2];
  logic [X_W-1:0]   xmin_q [2], xmin_d [2], xmax_q [2], xmax_d [2];
  logic [Y_W-1:0]   ymin_q [2], ymin_d [2], ymax_q [2], ymax_d [2];

  logic             res_valid_q, res_valid_d;
  logic [1:0]       found_q, found_d;
  logic [BOX_W-1:0] c1_box_q, c1_box_d, c2_box_q, c2_box_d;
  logic [CNT_W-1:0] c1_count_q, c1_count_d, c2_count_q, c2_count_d;
  logic             overrun_q, overrun_d;

  logic             acc, init, publish;
  logic [X_W-1:0]   px;
  logic [Y_W-1:0]   py;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    res_valid_d = res_valid_q;
    found_d     = found_q;
    c1_box_d    = c1_box_q;
    c2_box_d    = c2_box_q;
    c1_count_d  = c1_count_q;
    c2_count_d  = c2_count_q;
    overrun_d   = overrun_q;
    acc         = 1'b0;
    init        = 1'b0;
    publish     = 1'b0;
    px          = '0;
    py          = '0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.sof) begin
          acc     = 1'b1;
          init    = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc = 1'b1;
          // A mid-frame sof abandons the partial frame and restarts at (0,0).
          if (bus.sof) begin
            init = 1'b1;
          end else begin
            px = x_q;
            py = y_q;
            if (x_q == X_LAST && y_q == Y_LAST) state_d = FINISH;
          end
        end
      end
      FINISH: begin
        publish = 1'b1;
        state_d = IDLE;
        if (bus.in_valid && bus.sof) begin
          acc     = 1'b1;
          init    = 1'b1;
          state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase

    if (acc) begin
      if (px == X_LAST) begin
        x_d = '0;
        y_d = py + 1'b1;
      end else begin
        x_d = px + 1'b1;
        y_d = py;
      end
      for (int c = 0; c < 2; c++) begin
        if (init) begin
          cnt_d[c] = '0;
          hit_d[c] = 1'b0;
        end
        if (bus.colorEncoding[c]) begin
          if (cnt_d[c] != '1) cnt_d[c] = cnt_d[c] + 1'b1;
          if (!hit_d[c]) begin
            xmin_d[c] = px;
            xmax_d[c] = px;
            ymin_d[c] = py;
            ymax_d[c] = py;
            hit_d[c]  = 1'b1;
          end else begin
            if (px < xmin_d[c]) xmin_d[c] = px;
            if (px > xmax_d[c]) xmax_d[c] = px;
            if (py < ymin_d[c]) ymin_d[c] = py;
            if (py > ymax_d[c]) ymax_d[c] = py;
          end
        end
      end
    end

    if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end

    // Publishing reads the registered accumulators, so a frame starting in
    // the same cycle cannot disturb the result being copied out.
    if (publish) begin
      res_valid_d = 1'b1;
      if (res_valid_q && !bus.res_ready) overrun_d = 1'b1;
      found_d[1]  = (cnt_q[1] >= MIN_CNT);
      found_d[0]  = (cnt_q[0] >= MIN_CNT);
      c1_count_d  = cnt_q[1];
      c2_count_d  = cnt_q[0];
      c1_box_d    = (found_d[1] && hit_q[1]) ? {xmin_q[1], xmax_q[1], ymin_q[1], ymax_q[1]} : '0;
      c2_box_d    = (found_d[0] && hit_q[0]) ? {xmin_q[0], xmax_q[0], ymin_q[0], ymax_q[0]} : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      for (int c = 0; c < 2; c++) begin
        cnt_q[c]  <= '0;
        hit_q[c]  <= 1'b0;
        xmin_q[c] <= '0;
        xmax_q[c] <= '0;
        ymin_q[c] <= '0;
        ymax_q[c] <= '0;
      end
      res_valid_q <= 1'b0;
      found_q     <= '0;
      c1_box_q    <= '0;
      c2_box_q    <= '0;
      c1_count_q  <= '0;
      c2_count_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      res_valid_q <= res_valid_d;
      found_q     <= found_d;
      c1_box_q    <= c1_box_d;
      c2_box_q    <= c2_box_d;
      c1_count_q  <= c1_count_d;
      c2_count_q  <= c2_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.found     = found_q;
  assign bus.c1_box    = c1_box_q;
  assign bus.c2_box    = c2_box_q;
  assign bus.c1_count  = c1_count_q;
  assign bus.c2_count  = c2_count_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_color_bbox_accum.sv
// Bench for color_bbox_accum on a 4x4 image: two instances (MIN_PIX 1 and 3)
// share one pixel stream and are checked against a per-frame reference model.
module tb_color_bbox_accum;
  localparam int W = 4, H = 4, XW = 2, YW = 2, CW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, sof = 1'b0, res_ready = 1'b0;
  logic [1:0] enc = 2'b00;
  int checks = 0, failures = 0;
  logic [1:0] frame_px [16];

  color_bbox_accum_if #(.X_W(XW), .Y_W(YW), .CNT_W(CW)) ifa ();
  color_bbox_accum_if #(.X_W(XW), .Y_W(YW), .CNT_W(CW)) ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.sof = sof;            assign ifb.sof = sof;
  assign ifa.colorEncoding = enc;  assign ifb.colorEncoding = enc;
  assign ifa.res_ready = res_ready; assign ifb.res_ready = res_ready;

  color_bbox_accum #(.IMG_W(W), .IMG_H(H), .X_W(XW), .Y_W(YW), .CNT_W(CW), .MIN_PIX(1))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  color_bbox_accum #(.IMG_W(W), .IMG_H(H), .X_W(XW), .Y_W(YW), .CNT_W(CW), .MIN_PIX(3))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  // Expected output word {valid, found, c1_box, c1_count, c2_box, c2_count, overrun}
  // for the frame currently in frame_px.
  function automatic logic [29:0] model(input int minpix, input logic ov);
    int cnt [2], xmn [2], xmx [2], ymn [2], ymx [2];
    logic [1:0] fnd;
    logic [7:0] box [2];
    for (int c = 0; c < 2; c++) begin
      cnt[c] = 0; xmn[c] = W; xmx[c] = -1; ymn[c] = H; ymx[c] = -1;
    end
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (frame_px[i][1-c]) begin
          cnt[c]++;
          if (i % W < xmn[c]) xmn[c] = i % W;
          if (i % W > xmx[c]) xmx[c] = i % W;
          if (i / W < ymn[c]) ymn[c] = i / W;
          if (i / W > ymx[c]) ymx[c] = i / W;
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      fnd[1-c] = (cnt[c] >= minpix);
      box[c] = fnd[1-c] ? {2'(xmn[c]), 2'(xmx[c]), 2'(ymn[c]), 2'(ymx[c])} : 8'h00;
    end
    return {1'b1, fnd, box[0], 5'(cnt[0]), box[1], 5'(cnt[1]), ov};
  endfunction

  function automatic logic [59:0] obs();
    return {ifa.res_valid, ifa.found, ifa.c1_box, ifa.c1_count, ifa.c2_box, ifa.c2_count, ifa.overrun,
            ifb.res_valid, ifb.found, ifb.c1_box, ifb.c1_count, ifb.c2_box, ifb.c2_count, ifb.overrun};
  endfunction

  function automatic logic [59:0] expect_both(input logic ov);
    return {model(1, ov), model(3, ov)};
  endfunction

  task automatic pixel(input logic [1:0] e, input logic s, input int gap);
    @(negedge clk);
    in_valid = 1'b1; sof = s; enc = e;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0; sof = 1'($urandom); enc = 2'($urandom);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0; sof = 1'b0; enc = 2'b00;
  endtask

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < 16; i++)
      pixel(frame_px[i], i == 0, $urandom_range(0, maxgap));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++)
      frame_px[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 100; c++) begin
      if (ifa.res_valid && ifb.res_valid) break;
      @(negedge clk);
    end
  endtask

  task automatic ack();
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [59:0] o;
    o = obs();
    checks++;
    if (o !== 60'h0) begin
      $display("FAIL reset_outputs got=%h want=%h", o, 60'h0); failures++;
    end
    $display("txn reset outputs=%h", o);
  endtask

  task automatic test_reset_mid_accum();
    logic [59:0] o, e;
    fill_random(); send_frame(0); idle_in(); wait_valid();
    for (int i = 0; i < 7; i++) pixel(2'b11, i == 0, 0);
    @(negedge clk); reset_n = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ifa.res_valid !== 1'b0 || ifb.res_valid !== 1'b0) begin
        $display("FAIL reset_res_valid got=%b%b want=00", ifa.res_valid, ifb.res_valid); failures++;
      end
    end
    reset_n = 1'b1;
    fill_random(); send_frame(0); idle_in(); wait_valid();
    o = obs(); e = expect_both(1'b0);
    checks++;
    if (o !== e) begin
      $display("FAIL reset_mid_frame got=%h want=%h", o, e); failures++;
    end
    $display("txn reset_mid_frame result=%h", o);
    ack();
  endtask

  task automatic test_spec_frame();
    logic [59:0] o, e;
    foreach (frame_px[i]) frame_px[i] = 2'b00;
    frame_px[5] = 2'b10; frame_px[14] = 2'b10;
    send_frame(0); idle_in(); wait_valid();
    o = obs(); e = expect_both(1'b0);
    checks++;
    if (o !== e) begin
      $display("FAIL two_pixel_frame got=%h want=%h", o, e); failures++;
    end
    checks++;
    if ({ifa.found, ifa.c1_box, ifa.c1_count, ifa.c2_count, ifa.c2_box} !== {2'b10, 8'b01_10_01_11, 5'd2, 5'd0, 8'h00}) begin
      $display("FAIL two_pixel_literal got=%b/%h/%0d/%0d/%h want=10/67/2/0/00",
               ifa.found, ifa.c1_box, ifa.c1_count, ifa.c2_count, ifa.c2_box); failures++;
    end
    $display("txn two_pixel_frame result=%h", o);
    ack();
    checks++;
    if (ifa.res_valid !== 1'b0 || ifb.res_valid !== 1'b0) begin
      $display("FAIL drop_after_ack got=%b%b want=00", ifa.res_valid, ifb.res_valid); failures++;
    end
  endtask

  task automatic test_all_both();
    logic [59:0] o, e;
    foreach (frame_px[i]) frame_px[i] = 2'b11;
    send_frame(1); idle_in(); wait_valid();
    o = obs(); e = expect_both(1'b0);
    checks++;
    if (o !== e) begin
      $display("FAIL all_both_frame got=%h want=%h", o, e); failures++;
    end
    $display("txn all_both_frame result=%h", o);
    ack();
  endtask

  task automatic test_min_pix();
    logic [59:0] o, e;
    foreach (frame_px[i]) frame_px[i] = 2'b00;
    frame_px[2] = 2'b01; frame_px[9] = 2'b01; frame_px[3] = 2'b10;
    send_frame(0); idle_in(); wait_valid();
    o = obs(); e = expect_both(1'b0);
    checks++;
    if (o !== e) begin
      $display("FAIL min_pix_frame got=%h want=%h", o, e); failures++;
    end
    checks++;
    if ({ifb.found[0], ifb.c2_count, ifb.c2_box} !== {1'b0, 5'd2, 8'h00}) begin
      $display("FAIL min_pix_literal got=%b/%0d/%h want=0/2/00", ifb.found[0], ifb.c2_count, ifb.c2_box); failures++;
    end
    $display("txn min_pix_frame result=%h", o);
    ack();
  endtask

  task automatic test_sof_mid();
    logic [59:0] o, e;
    foreach (frame_px[i]) frame_px[i] = 2'b11;
    for (int i = 0; i < 7; i++) pixel(frame_px[i], i == 0, 0);
    fill_random(); send_frame(2); idle_in(); wait_valid();
    repeat (3) @(negedge clk);
    o = obs(); e = expect_both(1'b0);
    checks++;
    if (o !== e) begin
      $display("FAIL sof_mid_frame got=%h want=%h", o, e); failures++;
    end
    $display("txn sof_mid_frame result=%h", o);
    ack();
  endtask

  task automatic test_back_to_back();
    logic [59:0] o, e;
    res_ready = 1'b0;
    fill_random(); send_frame(0);
    fill_random(); send_frame(0); idle_in(); wait_valid();
    repeat (3) @(negedge clk);
    o = obs(); e = expect_both(1'b1);
    checks++;
    if (o !== e) begin
      $display("FAIL back_to_back_overrun got=%h want=%h", o, e); failures++;
    end
    $display("txn back_to_back result=%h", o);
    ack();
    checks++;
    if ({ifa.res_valid, ifa.overrun, ifb.res_valid, ifb.overrun} !== 4'b0000) begin
      $display("FAIL overrun_clear got=%b%b%b%b want=0000",
               ifa.res_valid, ifa.overrun, ifb.res_valid, ifb.overrun); failures++;
    end
  endtask

  task automatic test_gaps();
    logic [59:0] o, e;
    fill_random();
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 3; k++) pixel(2'b11, 1'b0, 0);
      idle_in();
      for (int i = 0; i < 16; i++) pixel(frame_px[i], i == 0, g);
      idle_in(); wait_valid();
      o = obs(); e = expect_both(1'b0);
      checks++;
      if (o !== e) begin
        $display("FAIL gap_%0d_frame got=%h want=%h", g, o, e); failures++;
      end
      $display("txn gap=%0d result=%h", g, o);
      ack();
    end
  endtask

  task automatic test_random();
    logic [59:0] o, e;
    for (int n = 0; n < 8; n++) begin
      fill_random(); send_frame(3); idle_in(); wait_valid();
      o = obs(); e = expect_both(1'b0);
      checks++;
      if (o !== e) begin
        $display("FAIL random_frame_%0d got=%h want=%h", n, o, e); failures++;
      end
      $display("txn random_frame=%0d result=%h", n, o);
      ack();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_reset_mid_accum();
    test_spec_frame();
    test_all_both();
    test_min_pix();
    test_sof_mid();
    test_back_to_back();
    test_gaps();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
